// File: rtl/sc_pkg.sv
// Shared types, signed-limit helpers and packed-result slicing for the
// stochastic-number up/down accumulator array.
package sc_pkg;

   // Run-control states of the accumulator array.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } sc_state_e;

   // Default accumulator width and its signed limits.
   localparam int ACC_W_DEF   = 8;
   localparam int ACC_MAX_DEF = (1 << (ACC_W_DEF - 1)) - 1;
   localparam int ACC_MIN_DEF = -(1 << (ACC_W_DEF - 1));

   // Largest positive two's-complement value of a w-bit accumulator.
   function automatic int acc_max_f(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   // Most negative two's-complement value of a w-bit accumulator.
   function automatic int acc_min_f(input int w);
      return -(1 << (w - 1));
   endfunction

   // LSB position of channel ch inside a packed result of w-bit lanes.
   function automatic int ch_lsb(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/sc_updown_lane.sv
// One bipolar SN accumulator lane: +1 per 1 bit, -1 per 0 bit, with
// optional clamping and a sticky overflow flag.
module sc_updown_lane
   import sc_pkg::*;
#(
   parameter int ACC_W = 8
) (
   input  logic                    i_clk_udc,
   input  logic                    i_rst_udc,
   input  logic                    clear_i,
   input  logic                    enable_i,
   input  logic                    bit_i,
   input  logic                    sat_en_i,
   output logic signed [ACC_W-1:0] acc_o,
   output logic                    ovf_o
);

   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max_f(ACC_W));
   localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min_f(ACC_W));

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    ovf_q, ovf_d;

   // Next value: clear wins, otherwise step up/down with clamp or wrap at the limits.
   always_comb begin
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (clear_i) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (enable_i) begin
         if (bit_i) begin
            if (acc_q == ACC_MAX) begin
               ovf_d = 1'b1;
               acc_d = sat_en_i ? ACC_MAX : ACC_MIN;
            end else begin
               acc_d = acc_q + 1'b1;
            end
         end else begin
            if (acc_q == ACC_MIN) begin
               ovf_d = 1'b1;
               acc_d = sat_en_i ? ACC_MIN : ACC_MAX;
            end else begin
               acc_d = acc_q - 1'b1;
            end
         end
      end
   end

   // Accumulator and sticky flag registers.
   always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
      if (i_rst_udc) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign acc_o = acc_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/sc_updown_acc_array.sv
// N_CH parallel bipolar SN accumulators sharing one run controller with a
// start/done handshake and a programmable stream length.
module sc_updown_acc_array
   import sc_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int ACC_W = 8,
   parameter int LEN_W = 8
) (
   input  logic                  i_clk_udc,
   input  logic                  i_rst_udc,
   input  logic                  i_start,
   input  logic [LEN_W-1:0]      i_len,
   input  logic                  i_sat_en,
   input  logic                  i_bit_valid,
   input  logic [N_CH-1:0]       i_sn_bits,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_valid,
   output logic [N_CH*ACC_W-1:0] o_acc,
   output logic [N_CH-1:0]       o_ovf
);

   sc_state_e        state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             sat_q, sat_d;
   logic             valid_q, valid_d;
   logic             clear;
   logic             enable;

   // Run controller: a start is accepted in every state and restarts the run;
   // beats count only in ACC and never in the start cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      sat_d   = sat_q;
      valid_d = valid_q;
      clear   = 1'b0;
      enable  = 1'b0;
      if (i_start) begin
         clear   = 1'b1;
         cnt_d   = '0;
         len_d   = i_len;
         sat_d   = i_sat_en;
         valid_d = 1'b0;
         if (i_len == '0) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
         end else begin
            state_d = ST_ACC;
         end
      end else begin
         case (state_q)
            ST_ACC: begin
               if (i_bit_valid) begin
                  enable = 1'b1;
                  cnt_d  = cnt_q + 1'b1;
                  if (cnt_q == LEN_W'(len_q - 1'b1)) begin
                     state_d = ST_DONE;
                     valid_d = 1'b1;
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Controller state registers.
   always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
      if (i_rst_udc) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         sat_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         sat_q   <= sat_d;
         valid_q <= valid_d;
      end
   end

   assign o_busy  = (state_q == ST_ACC);
   assign o_done  = (state_q == ST_DONE);
   assign o_valid = valid_q;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_lane
         sc_updown_lane #(
            .ACC_W (ACC_W)
         ) u_lane (
            .i_clk_udc (i_clk_udc),
            .i_rst_udc (i_rst_udc),
            .clear_i   (clear),
            .enable_i  (enable),
            .bit_i     (i_sn_bits[gi]),
            .sat_en_i  (sat_q),
            .acc_o     (o_acc[ch_lsb(gi, ACC_W) +: ACC_W]),
            .ovf_o     (o_ovf[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_sc_updown_acc_array.sv
// Directed bench for sc_updown_acc_array: an 8-bit instance for the main
// function and a 4-bit instance for saturate/wrap behaviour.
module tb_sc_updown_acc_array;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic        sat_en = 1'b0;
   logic        bit_valid = 1'b0;
   logic [3:0]  bits = '0;

   logic        busy8, done8, valid8;
   logic [31:0] acc8;
   logic [3:0]  ovf8;
   logic        busy4, done4, valid4;
   logic [15:0] acc4;
   logic [3:0]  ovf4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sc_updown_acc_array #(.N_CH(4), .ACC_W(8), .LEN_W(8)) dut8 (
      .i_clk_udc (clk), .i_rst_udc (rst), .i_start (start), .i_len (len),
      .i_sat_en (sat_en), .i_bit_valid (bit_valid), .i_sn_bits (bits),
      .o_busy (busy8), .o_done (done8), .o_valid (valid8), .o_acc (acc8), .o_ovf (ovf8)
   );

   sc_updown_acc_array #(.N_CH(4), .ACC_W(4), .LEN_W(8)) dut4 (
      .i_clk_udc (clk), .i_rst_udc (rst), .i_start (start), .i_len (len),
      .i_sat_en (sat_en), .i_bit_valid (bit_valid), .i_sn_bits (bits),
      .o_busy (busy4), .o_done (done4), .o_valid (valid4), .o_acc (acc4), .o_ovf (ovf4)
   );

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if ({busy8, done8, valid8, acc8, ovf8} !== 39'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h expected 0", {busy8, done8, valid8, acc8, ovf8});
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({busy8, done8, valid8} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_idle: got %b expected 000", {busy8, done8, valid8});
      end
      $display("test_reset: busy=%b done=%b valid=%b acc=%h", busy8, done8, valid8, acc8);
   endtask

   task automatic test_all_ones();
      start = 1'b1; len = 8'd8; sat_en = 1'b1; bit_valid = 1'b1; bits = 4'hF;
      tick();
      start = 1'b0;
      n_cmp++;
      if ({busy8, valid8, acc8} !== {1'b1, 1'b0, 32'h0}) begin
         n_err++;
         $display("FAIL ones_start: got busy=%b valid=%b acc=%h expected 1 0 0", busy8, valid8, acc8);
      end
      for (int i = 0; i < 7; i++) tick();
      n_cmp++;
      if (done8 !== 1'b0) begin
         n_err++;
         $display("FAIL ones_early_done: got %b expected 0", done8);
      end
      tick();
      bit_valid = 1'b0;
      n_cmp++;
      if ({done8, busy8, valid8, acc8, ovf8} !== {3'b101, 32'h08080808, 4'h0}) begin
         n_err++;
         $display("FAIL ones_result: got done=%b busy=%b valid=%b acc=%h ovf=%h expected 1 0 1 08080808 0",
                  done8, busy8, valid8, acc8, ovf8);
      end
      tick();
      n_cmp++;
      if ({done8, valid8, acc8} !== {2'b01, 32'h08080808}) begin
         n_err++;
         $display("FAIL ones_done_pulse: got done=%b valid=%b acc=%h expected 0 1 08080808", done8, valid8, acc8);
      end
      $display("test_all_ones: acc=%h ovf=%h", acc8, ovf8);
   endtask

   task automatic test_mixed();
      start = 1'b1; len = 8'd8; sat_en = 1'b1; bit_valid = 1'b0;
      tick();
      start = 1'b0; bit_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bits[0] = 1'b0;
         bits[1] = (i % 2 == 0);
         bits[2] = (i < 6);
         bits[3] = 1'b1;
         tick();
      end
      bit_valid = 1'b0;
      n_cmp++;
      if ({done8, acc8, ovf8} !== {1'b1, 32'h080400F8, 4'h0}) begin
         n_err++;
         $display("FAIL mixed_result: got done=%b acc=%h ovf=%h expected 1 080400f8 0", done8, acc8, ovf8);
      end
      tick();
      $display("test_mixed: acc=%h", acc8);
   endtask

   // Saturating run on the 4-bit instance, then a wrapping run started in its done cycle.
   task automatic test_sat_wrap_back_to_back();
      start = 1'b1; len = 8'd15; sat_en = 1'b1; bit_valid = 1'b0; bits = 4'hF;
      tick();
      start = 1'b0; bit_valid = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      n_cmp++;
      if ({done4, acc4, ovf4} !== {1'b1, 16'h7777, 4'hF}) begin
         n_err++;
         $display("FAIL sat_result: got done=%b acc=%h ovf=%h expected 1 7777 f", done4, acc4, ovf4);
      end
      $display("test_sat: acc=%h ovf=%h", acc4, ovf4);
      start = 1'b1; sat_en = 1'b0;
      tick();
      start = 1'b0; sat_en = 1'b1;
      n_cmp++;
      if ({busy4, valid4, acc4, ovf4} !== {2'b10, 16'h0, 4'h0}) begin
         n_err++;
         $display("FAIL b2b_restart: got busy=%b valid=%b acc=%h ovf=%h expected 1 0 0 0", busy4, valid4, acc4, ovf4);
      end
      for (int i = 0; i < 15; i++) tick();
      bit_valid = 1'b0;
      n_cmp++;
      if ({done4, acc4, ovf4} !== {1'b1, 16'hFFFF, 4'hF}) begin
         n_err++;
         $display("FAIL wrap_result: got done=%b acc=%h ovf=%h expected 1 ffff f", done4, acc4, ovf4);
      end
      tick();
      $display("test_wrap: acc=%h ovf=%h", acc4, ovf4);
   endtask

   task automatic test_bubbles();
      logic [6:0] vseq;
      vseq = 7'b1011001; // bit j is bit_valid in beat cycle j: 1,0,0,1,1,0,1
      start = 1'b1; len = 8'd4; sat_en = 1'b1; bit_valid = 1'b0; bits = 4'hF;
      tick();
      start = 1'b0;
      for (int j = 0; j < 6; j++) begin
         bit_valid = vseq[j];
         tick();
      end
      n_cmp++;
      if ({done8, busy8} !== 2'b01) begin
         n_err++;
         $display("FAIL bubble_early: got done=%b busy=%b expected 0 1", done8, busy8);
      end
      bit_valid = vseq[6];
      tick();
      bit_valid = 1'b0;
      n_cmp++;
      if ({done8, acc8} !== {1'b1, 32'h04040404}) begin
         n_err++;
         $display("FAIL bubble_result: got done=%b acc=%h expected 1 04040404", done8, acc8);
      end
      tick();
      $display("test_bubbles: acc=%h", acc8);
   endtask

   task automatic test_zero_len();
      start = 1'b1; len = 8'd0; bit_valid = 1'b1; bits = 4'hF;
      tick();
      start = 1'b0; bit_valid = 1'b0;
      n_cmp++;
      if ({done8, busy8, valid8, acc8} !== {3'b101, 32'h0}) begin
         n_err++;
         $display("FAIL zero_len: got done=%b busy=%b valid=%b acc=%h expected 1 0 1 0", done8, busy8, valid8, acc8);
      end
      tick();
      $display("test_zero_len: acc=%h", acc8);
   endtask

   task automatic test_restart_hold();
      start = 1'b1; len = 8'd8; sat_en = 1'b1; bit_valid = 1'b0; bits = 4'hF;
      tick();
      start = 1'b0; bit_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      start = 1'b1; bits = 4'h0;  // beats in the restart cycle are discarded
      tick();
      start = 1'b0; bits = 4'hF;
      n_cmp++;
      if ({busy8, acc8} !== {1'b1, 32'h0}) begin
         n_err++;
         $display("FAIL restart_clear: got busy=%b acc=%h expected 1 0", busy8, acc8);
      end
      for (int i = 0; i < 7; i++) tick();
      n_cmp++;
      if (done8 !== 1'b0) begin
         n_err++;
         $display("FAIL restart_early_done: got %b expected 0", done8);
      end
      tick();
      n_cmp++;
      if ({done8, acc8} !== {1'b1, 32'h08080808}) begin
         n_err++;
         $display("FAIL restart_result: got done=%b acc=%h expected 1 08080808", done8, acc8);
      end
      for (int i = 0; i < 4; i++) begin
         bits = 4'(i * 5);
         sat_en = i[0];
         len = 8'(i);
         tick();
      end
      bit_valid = 1'b0;
      n_cmp++;
      if ({busy8, valid8, acc8} !== {2'b01, 32'h08080808}) begin
         n_err++;
         $display("FAIL hold_result: got busy=%b valid=%b acc=%h expected 0 1 08080808", busy8, valid8, acc8);
      end
      $display("test_restart_hold: acc=%h", acc8);
   endtask

   task automatic test_reset_mid();
      start = 1'b1; len = 8'd8; sat_en = 1'b1; bit_valid = 1'b0; bits = 4'hF;
      tick();
      start = 1'b0; bit_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy8, done8, valid8, acc8, ovf8} !== 39'd0) begin
         n_err++;
         $display("FAIL async_reset: got %h expected 0", {busy8, done8, valid8, acc8, ovf8});
      end
      #1 rst = 1'b0;
      bit_valid = 1'b0;
      tick();
      start = 1'b1; len = 8'd2;
      tick();
      start = 1'b0; bit_valid = 1'b1;
      tick();
      tick();
      bit_valid = 1'b0;
      n_cmp++;
      if ({done8, acc8} !== {1'b1, 32'h02020202}) begin
         n_err++;
         $display("FAIL post_reset_run: got done=%b acc=%h expected 1 02020202", done8, acc8);
      end
      tick();
      $display("test_reset_mid: acc=%h", acc8);
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_mixed();
      test_sat_wrap_back_to_back();
      test_bubbles();
      test_zero_len();
      test_restart_hold();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sc_updown_acc_array.md
# sc_updown_acc_array

Parametrised array of bipolar stochastic-number accumulators that turns N_CH parallel SN bitstreams into signed counts. Each channel adds +1 for a 1 bit and −1 for a 0 bit over a programmed stream length. It has a start/done handshake, optional saturation and per-channel overflow flags. It sits after the FSM_MUX/DCounter stage of the MVM datapath and supersedes the fixed 4-lane, 4-bit up/down counters.

## Interface
Parameters:
- N_CH, 4, number of parallel channels (≥1)
- ACC_W, 8, signed accumulator width per channel (≥2)
- LEN_W, 8, width of stream-length field

Ports:
- i_clk_udc  in  1  clock, rising edge
- i_rst_udc  in  1  reset, asynchronous, active-high
- i_start  in  1  single-cycle request to begin a run; latches i_len and i_sat_en
- i_len  in  LEN_W  number of valid beats in the run (0 allowed)
- i_sat_en  in  1  1 = clamp at signed limits; 0 = two's-complement wrap
- i_bit_valid  in  1  qualifies i_sn_bits this cycle
- i_sn_bits  in  N_CH  one SN bit per channel
- o_busy  out  1  high in ACC state
- o_done  out  1  one-cycle pulse when a run completes
- o_valid  out  1  o_acc holds a completed result
- o_acc  out  N_CH×ACC_W  signed per-channel result, packed with channel 0 in the LSBs
- o_ovf  out  N_CH  sticky per-run flag: the channel clamped (sat) or wrapped (no sat)

## Operation
- States: IDLE, ACC, DONE.
- IDLE behaviour:
  - When i_start=1: clear all accumulators, o_ovf and the beat counter, and drop o_valid.
  - Latch len and sat_en.
  - Next state is ACC, or DONE when i_len=0.
- ACC, beat handling:
  - Each cycle with i_bit_valid=1, every channel updates acc ← acc+1 if its bit is 1, else acc−1.
  - The beat counter increments.
  - Cycles with i_bit_valid=0 change nothing.
- ACC, saturation and overflow:
  - sat_en=1: an update that would pass +(2^(ACC_W−1)−1) or −2^(ACC_W−1) holds at the limit and sets o_ovf[ch].
  - sat_en=0: the accumulator wraps and o_ovf[ch] is set on the wrap.
- ACC, completion: the valid beat with beat counter = len−1 is the last beat; next state is DONE.
- ACC, restart: i_start=1 in ACC aborts the run and restarts it exactly as from IDLE. Beats in that cycle are discarded.
- DONE: o_done=1 for exactly one cycle, o_valid is set, and the state returns to IDLE.
- Result hold: o_acc and o_ovf hold until the next accepted i_start. i_start in DONE is accepted as from IDLE.
- Reset: asynchronous reset at any time, including mid-run, forces IDLE. All accumulators, o_ovf, o_busy, o_done and o_valid go to 0.
- Value interpretation is done downstream, not in this block: bipolar value = acc/len.

## Timing
- Reset values: o_busy=0, o_done=0, o_valid=0, o_acc=0, o_ovf=0.
- Start: i_start sampled high at edge t gives o_busy=1 from t+1, and o_valid=0 and o_acc=0 visible from t+1.
- Sampling: the first beat sampled is at edge t+1. A beat presented together with i_start is ignored.
- Latency: the last valid beat sampled at edge k gives final o_acc visible from k+1, with o_done=1 and o_busy=0 during cycle k+1. o_valid=1 from k+1.
- Zero length: i_len=0 gives o_done at t+1 with o_acc=0.
- Throughput: a new i_start may be issued in the o_done cycle, giving back-to-back runs with 1 idle cycle.
- i_len and i_sat_en are don't-care outside the i_start cycle.

## Structure
- Package sc_pkg:
  - state enum (IDLE/ACC/DONE)
  - localparams for signed limits derived from ACC_W
  - the packed-result slicing helper
- Sub-module sc_updown_lane, instantiated N_CH times by generate:
  - inputs: clear, enable, bit, sat_en
  - outputs: acc and sticky ovf
- The parent holds the FSM, beat counter and latched len/sat_en.

## Test plan
- All ones, no overflow: N_CH=4, ACC_W=8, len=8, all bits 1 with sat_en=1 → o_acc=+8 each, o_ovf=0, o_done 1 cycle after the 8th beat.
- Mixed patterns: same config; ch0 all 0, ch1 alternating 1/0, ch2 six 1s then two 0s, ch3 all 1 → o_acc = −8, 0, +4, +8.
- Saturate vs wrap: ACC_W=4, len=15, all 1s:
  - sat_en=1 → acc=+7 and o_ovf=1 for all channels.
  - sat_en=0 → acc=−1 (wrapped) and o_ovf=1.
- Bubbles and zero length:
  - len=4 with i_bit_valid toggling 1,0,0,1,1,0,1 → done one cycle after the 4th valid beat; bubble cycles do not count.
  - len=0 → o_done at t+1 with o_acc=0.
- Restart and hold: i_start again after 3 beats of a len=8 run → accumulators clear, and a full 8 new beats are required. After done, o_acc holds while idle inputs toggle.
- Reset mid-run: assert i_rst_udc asynchronously (between edges) during ACC → all outputs 0 immediately. A subsequent run of len=2 with bits 1,1 → o_acc=+2.
